// File: rtl/pipe_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : pipe_ctrl_pkg
// Brief   : Shared encodings for the pipeline control sequencer.
// Rev     : 1.0
// ============================================================================
package pipe_ctrl_pkg;

    localparam logic        RstEnable = 1'b1;
    localparam logic        Stop      = 1'b1;
    localparam logic        NoStop    = 1'b0;
    localparam logic [31:0] ZeroWord  = 32'h0000_0000;

    // bit0 = pc ... bit5 = wb
    localparam logic [5:0] STALL_NONE = 6'b000000;
    localparam logic [5:0] STALL_IF   = 6'b000011;
    localparam logic [5:0] STALL_ID   = 6'b000111;
    localparam logic [5:0] STALL_EX   = 6'b001111;
    localparam logic [5:0] STALL_MEM  = 6'b011111;
    localparam logic [5:0] STALL_ALL  = 6'b111111;

    localparam logic [31:0] EXC_ERET           = 32'h0000_000e;
    localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'h0000_0020;

    typedef enum logic [1:0] {
        CTRL_RUN    = 2'd0,
        CTRL_HOLD   = 2'd1,
        CTRL_FLUSH  = 2'd2,
        CTRL_REFILL = 2'd3
    } ctrl_state_t;

endpackage : pipe_ctrl_pkg
`default_nettype wire

// File: rtl/pipe_ctrl_stall_wdt.sv
`default_nettype none
// ============================================================================
// Module  : stall_wdt
// Brief   : Saturating consecutive-stall counter with a sticky timeout flag.
// Rev     : 1.0
// ============================================================================
module stall_wdt #(
    parameter int               WDT_W     = 16,
    parameter logic [WDT_W-1:0] WDT_LIMIT = 16'd1024
) (
    input  logic clk,
    input  logic rst,
    input  logic i_stall_active,
    input  logic i_flush,
    output logic o_timeout
);

    localparam logic [WDT_W-1:0] c_ONE = {{(WDT_W-1){1'b0}}, 1'b1};

    logic [WDT_W-1:0] r_cnt;
    logic             r_timeout;
    logic [WDT_W-1:0] w_cnt_nxt;

    always_comb begin
        w_cnt_nxt = r_cnt;
        if (!i_stall_active || i_flush)
            w_cnt_nxt = '0;
        else if (r_cnt != '1)
            w_cnt_nxt = r_cnt + c_ONE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt     <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_cnt <= w_cnt_nxt;
            if (w_cnt_nxt >= WDT_LIMIT)
                r_timeout <= 1'b1;
        end
    end

    assign o_timeout = r_timeout;

endmodule : stall_wdt
`default_nettype wire

// File: rtl/pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : pipe_ctrl
// Brief   : Stall merge and exception/eret flush sequencer for the 6-stage
//           core. Optional stall watchdog under PIPE_CTRL_STALL_WDT_EN.
// Rev     : 1.0
// ============================================================================
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0020,
    parameter logic [31:0] ERET_CODE  = 32'h0000_000e,
    parameter int          WDT_W      = 16,
    parameter logic [WDT_W-1:0] WDT_LIMIT = 16'd1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallreq_if_i,
    input  logic        stallreq_id_i,
    input  logic        stallreq_ex_i,
    input  logic        stallreq_mem_i,
    input  logic [31:0] excepttype_i,
    input  logic [31:0] cp0_epc_i,
    output logic [5:0]  stall_o,
    output logic        flush_o,
    output logic [31:0] new_pc_o,
    output logic        wdt_timeout_o
);

    ctrl_state_t r_state;
    ctrl_state_t w_state_nxt;
    logic [31:0] r_new_pc;
    logic [5:0]  w_req_stall;
    logic [5:0]  w_stall;
    logic        w_flush;
    logic        w_exc_take;

    always_comb begin
        if (stallreq_mem_i)      w_req_stall = STALL_MEM;
        else if (stallreq_ex_i)  w_req_stall = STALL_EX;
        else if (stallreq_id_i)  w_req_stall = STALL_ID;
        else if (stallreq_if_i)  w_req_stall = STALL_IF;
        else                     w_req_stall = STALL_NONE;
    end

    // A mem-stage exception waits for the data bus so the faulting access is stable.
    assign w_exc_take = (r_state == CTRL_RUN) && (excepttype_i != ZeroWord) && !stallreq_mem_i;

    always_comb begin
        w_stall     = w_req_stall;
        w_flush     = 1'b0;
        w_state_nxt = r_state;
        case (r_state)
            CTRL_RUN: begin
                if (w_exc_take) begin
                    w_stall     = STALL_ALL;
                    w_state_nxt = CTRL_HOLD;
                end
            end
            CTRL_HOLD: begin
                w_stall     = STALL_ALL;
                w_state_nxt = CTRL_FLUSH;
            end
            CTRL_FLUSH: begin
                w_stall     = STALL_NONE;
                w_flush     = 1'b1;
                w_state_nxt = CTRL_REFILL;
            end
            CTRL_REFILL: begin
                w_state_nxt = CTRL_RUN;
            end
            default: begin
                w_state_nxt = CTRL_RUN;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= CTRL_RUN;
            r_new_pc <= ZeroWord;
        end else begin
            r_state <= w_state_nxt;
            if (w_exc_take)
                r_new_pc <= (excepttype_i == ERET_CODE) ? cp0_epc_i : EXC_VECTOR;
        end
    end

    assign stall_o  = rst ? STALL_NONE : w_stall;
    assign flush_o  = rst ? 1'b0 : w_flush;
    assign new_pc_o = r_new_pc;

`ifdef PIPE_CTRL_STALL_WDT_EN
    stall_wdt #(
        .WDT_W     (WDT_W),
        .WDT_LIMIT (WDT_LIMIT)
    ) u_stall_wdt (
        .clk            (clk),
        .rst            (rst),
        .i_stall_active (stall_o != STALL_NONE),
        .i_flush        (flush_o),
        .o_timeout      (wdt_timeout_o)
    );
`else
    assign wdt_timeout_o = 1'b0;
`endif

endmodule : pipe_ctrl
`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_pipe_ctrl
// Brief   : Directed self-checking bench for pipe_ctrl.
// Rev     : 1.0
// ============================================================================
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stallreq_if_i = 1'b0;
    logic        stallreq_id_i = 1'b0;
    logic        stallreq_ex_i = 1'b0;
    logic        stallreq_mem_i = 1'b0;
    logic [31:0] excepttype_i = 32'h0;
    logic [31:0] cp0_epc_i = 32'h0;
    logic [5:0]  stall_o;
    logic        flush_o;
    logic [31:0] new_pc_o;
    logic        wdt_timeout_o;

    int n_tests = 0;
    int n_fail  = 0;

`ifdef PIPE_CTRL_STALL_WDT_EN
    localparam logic EXP_WDT_LONG = 1'b1;
`else
    localparam logic EXP_WDT_LONG = 1'b0;
`endif

    pipe_ctrl #(
        .EXC_VECTOR (32'h0000_0020),
        .ERET_CODE  (32'h0000_000e),
        .WDT_W      (16),
        .WDT_LIMIT  (16'd8)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .stallreq_if_i  (stallreq_if_i),
        .stallreq_id_i  (stallreq_id_i),
        .stallreq_ex_i  (stallreq_ex_i),
        .stallreq_mem_i (stallreq_mem_i),
        .excepttype_i   (excepttype_i),
        .cp0_epc_i      (cp0_epc_i),
        .stall_o        (stall_o),
        .flush_o        (flush_o),
        .new_pc_o       (new_pc_o),
        .wdt_timeout_o  (wdt_timeout_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive new inputs just after the falling edge; outputs settle before sampling.
    task automatic step(input logic f_if, input logic f_id, input logic f_ex,
                        input logic f_mem, input logic [31:0] exc);
        @(negedge clk);
        stallreq_if_i  = f_if;
        stallreq_id_i  = f_id;
        stallreq_ex_i  = f_ex;
        stallreq_mem_i = f_mem;
        excepttype_i   = exc;
        #1;
    endtask

    initial begin
        // Reset
        repeat (2) @(negedge clk);
        rst = 1'b0;
        step(0, 0, 0, 0, 32'h0);
        chk("reset_stall", {26'h0, stall_o}, 32'h00);
        chk("reset_flush", {31'h0, flush_o}, 32'h0);
        chk("reset_newpc", new_pc_o, 32'h0);
        chk("reset_wdt", {31'h0, wdt_timeout_o}, 32'h0);

        // Priority merge
        step(0, 1, 1, 0, 32'h0);
        chk("id_ex_stall", {26'h0, stall_o}, 32'h0f);
        step(0, 1, 0, 0, 32'h0);
        chk("id_stall", {26'h0, stall_o}, 32'h07);
        step(1, 0, 0, 0, 32'h0);
        chk("if_stall", {26'h0, stall_o}, 32'h03);
        step(1, 1, 1, 1, 32'h0);
        chk("mem_stall", {26'h0, stall_o}, 32'h1f);

        // Syscall sequence
        step(1, 0, 1, 0, 32'h8);
        chk("sys_N_stall", {26'h0, stall_o}, 32'h3f);
        chk("sys_N_flush", {31'h0, flush_o}, 32'h0);
        step(0, 0, 0, 0, 32'h0);
        chk("sys_hold_stall", {26'h0, stall_o}, 32'h3f);
        chk("sys_hold_newpc", new_pc_o, 32'h20);
        step(0, 0, 0, 0, 32'h0);
        chk("sys_flush", {31'h0, flush_o}, 32'h1);
        chk("sys_flush_stall", {26'h0, stall_o}, 32'h00);
        chk("sys_flush_newpc", new_pc_o, 32'h20);
        step(0, 1, 0, 0, 32'h0);
        chk("sys_refill_flush", {31'h0, flush_o}, 32'h0);
        chk("sys_refill_stall", {26'h0, stall_o}, 32'h07);

        // Back-to-back eret in the first RUN cycle after REFILL
        cp0_epc_i = 32'h0000_1234;
        step(0, 0, 0, 0, 32'he);
        chk("eret_N_stall", {26'h0, stall_o}, 32'h3f);
        step(0, 0, 0, 0, 32'h0);
        chk("eret_hold_stall", {26'h0, stall_o}, 32'h3f);
        step(0, 0, 0, 0, 32'h0);
        chk("eret_flush", {31'h0, flush_o}, 32'h1);
        chk("eret_newpc", new_pc_o, 32'h1234);
        step(0, 0, 0, 0, 32'hc);
        chk("refill_ign_stall", {26'h0, stall_o}, 32'h00);
        chk("refill_ign_flush", {31'h0, flush_o}, 32'h0);
        step(0, 0, 0, 0, 32'h0);
        chk("post_refill_flush", {31'h0, flush_o}, 32'h0);
        step(0, 0, 0, 0, 32'h0);
        chk("post_refill2_flush", {31'h0, flush_o}, 32'h0);
        chk("post_refill_stall", {26'h0, stall_o}, 32'h00);
        chk("newpc_held", new_pc_o, 32'h1234);

        // Exception deferred behind a mem stall
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 1, 32'hc);
            chk("defer_stall", {26'h0, stall_o}, 32'h1f);
            chk("defer_flush", {31'h0, flush_o}, 32'h0);
        end
        step(0, 0, 0, 0, 32'hc);
        chk("defer_take_stall", {26'h0, stall_o}, 32'h3f);
        step(0, 0, 0, 0, 32'h0);
        chk("defer_hold_stall", {26'h0, stall_o}, 32'h3f);
        step(0, 0, 0, 0, 32'h0);
        chk("defer_flush_pulse", {31'h0, flush_o}, 32'h1);
        chk("defer_newpc", new_pc_o, 32'h20);
        step(0, 0, 0, 0, 32'h0);
        step(0, 0, 0, 0, 32'h0);

        // Asynchronous reset mid-HOLD
        cp0_epc_i = 32'h0000_5678;
        step(0, 0, 0, 0, 32'he);
        step(0, 0, 0, 0, 32'h0);
        chk("pre_rst_hold", {26'h0, stall_o}, 32'h3f);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_stall", {26'h0, stall_o}, 32'h00);
        chk("async_rst_newpc", new_pc_o, 32'h0);
        chk("async_rst_flush", {31'h0, flush_o}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        step(0, 0, 0, 0, 32'h0);
        chk("after_rst_flush", {31'h0, flush_o}, 32'h0);
        chk("after_rst_stall", {26'h0, stall_o}, 32'h00);

        // Watchdog: 7 stalled cycles stays quiet, 8 trips the sticky flag
        for (int i = 0; i < 7; i++) step(0, 0, 1, 0, 32'h0);
        step(0, 0, 0, 0, 32'h0);
        chk("wdt_7_cycles", {31'h0, wdt_timeout_o}, 32'h0);
        for (int i = 0; i < 8; i++) step(0, 0, 1, 0, 32'h0);
        step(0, 0, 0, 0, 32'h0);
        chk("wdt_8_cycles", {31'h0, wdt_timeout_o}, {31'h0, EXP_WDT_LONG});
        step(0, 0, 0, 0, 32'h0);
        step(0, 0, 0, 0, 32'h0);
        chk("wdt_sticky", {31'h0, wdt_timeout_o}, {31'h0, EXP_WDT_LONG});
        chk("wdt_no_side_effect", {26'h0, stall_o}, 32'h00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_pipe_ctrl
`default_nettype wire

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Pipeline control sequencer for the 6-stage core: pc, if, id, ex, mem, wb.
- Merges stall requests from the if/id/ex/mem stages into the `stall` vector that every pipeline register (including ex/mem) samples.
- Sequences exception and eret handling through a small FSM: freeze the pipeline, issue a one-cycle flush with the redirect PC, then perform a guarded refill.
- Sits beside the pipeline registers and drives their `stall`/`flush` inputs and the pc register's `new_pc`.

Parameters:
- EXC_VECTOR, 32'h00000020, redirect target for every non-eret exception.
- ERET_CODE, 32'h0000000e, excepttype value meaning eret (redirect to EPC).
- WDT_W, 16, width of the stall watchdog counter.
- WDT_LIMIT, 16'd1024, consecutive stalled cycles that trip the watchdog.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset; asynchronous, active-high (`RstEnable = 1'b1`).
- stallreq_if_i  in  1  instruction fetch bus wait.
- stallreq_id_i  in  1  load-use / decode hazard.
- stallreq_ex_i  in  1  multi-cycle div/madd busy.
- stallreq_mem_i  in  1  data bus wait.
- excepttype_i  in  32  mem-stage exception code; 0 means none.
- cp0_epc_i  in  32  current EPC, already forwarded.
- stall_o  out  6  bit0=pc … bit5=wb; 1 = hold stage.
- flush_o  out  1  clear all pipeline registers.
- new_pc_o  out  32  redirect PC; meaningful only while flush_o=1.
- wdt_timeout_o  out  1  sticky watchdog flag.

Behaviour:
- Reset (asynchronous, any state including mid-FLUSH):
  - state=RUN, new_pc_o=0, watchdog count=0, wdt_timeout_o=0.
  - stall_o=6'b000000 and flush_o=0 while rst is high.
- FSM states: RUN, HOLD, FLUSH, REFILL. Outputs are decoded combinationally from state and inputs; state and new_pc_o are registered.
- RUN, normal stalls. Highest-priority request wins:
  - mem → 6'b011111
  - ex → 6'b001111
  - id → 6'b000111
  - if → 6'b000011
  - none → 6'b000000
  - flush_o=0.
- RUN, exception handling:
  - excepttype_i!=0 and stallreq_mem_i=0 → stall_o=6'b111111 this cycle, so the faulting instruction cannot commit to wb. Next state HOLD.
  - new_pc_o latched at this edge: cp0_epc_i if excepttype_i==ERET_CODE, else EXC_VECTOR.
  - excepttype_i!=0 with stallreq_mem_i=1 → the exception is deferred: stay in RUN with stall 6'b011111. It is re-evaluated each cycle until the mem stall drops.
  - The exception has priority over if/id/ex requests.
- HOLD: stall_o=6'b111111, flush_o=0. Gives cp0 one cycle to commit EPC/cause. Next state FLUSH unconditionally.
- FLUSH: flush_o=1 for exactly one cycle, stall_o=6'b000000, new_pc_o stable. Next state REFILL.
- REFILL (one cycle):
  - excepttype_i is ignored (bubbles are in flight).
  - Stall requests are honoured exactly as in RUN; flush_o=0.
  - Next state RUN.
- Back-to-back: an exception presented in the first RUN cycle after REFILL is accepted normally. Minimum spacing between two flush pulses is 4 cycles.
- new_pc_o holds its last latched value outside FLUSH and never changes while in HOLD/FLUSH.
- Stall vectors are always a contiguous low-order run of 1s (monotone); no other patterns are generated.

Optional Feature:
- Macro: PIPE_CTRL_STALL_WDT_EN.
- Enabled:
  - A WDT_W-bit counter increments on every cycle with stall_o!=0 and is cleared on any cycle with stall_o==0 or flush_o=1.
  - The counter saturates at its maximum.
  - When count reaches WDT_LIMIT, wdt_timeout_o is set and stays 1 until rst. Pipeline behaviour is unaffected.
- Disabled: no counter logic; wdt_timeout_o tied to 0.

Decomposition:
- Shared def package/include additions:
  - stall encodings STALL_NONE/IF/ID/EX/MEM/ALL.
  - State encodings CTRL_RUN/HOLD/FLUSH/REFILL (2-bit).
  - EXC_ERET code and EXC_VECTOR default, alongside the existing RstEnable/Stop/NoStop/ZeroWord.
- One natural sub-module: stall_wdt, holding the watchdog counter and sticky flag. Instantiated only under PIPE_CTRL_STALL_WDT_EN.
- The FSM and stall priority encoder stay in pipe_ctrl.

Test Plan:
- Reset, then all requests 0 → stall_o=000000, flush_o=0. Assert rst mid-HOLD → state RUN and all outputs 0 immediately, without waiting for clk.
- stallreq_id_i=1 and stallreq_ex_i=1 in the same cycle → stall_o=001111. Drop ex → 000111 the same cycle.
- excepttype_i=32'h8 (syscall) for one cycle:
  - cycle N: stall_o=111111.
  - N+1: HOLD, 111111.
  - N+2: flush_o=1, new_pc_o=32'h20.
  - N+3: REFILL with flush_o=0.
- excepttype_i=32'he with cp0_epc_i=32'h0000_1234 → the flush cycle shows new_pc_o=32'h1234. An excepttype_i=32'hc during REFILL is ignored (no second flush).
- excepttype_i=32'hc with stallreq_mem_i=1 for 3 cycles → stall_o=011111 for those 3 cycles, then 111111 on the cycle mem drops. Flush follows 2 cycles later.
- With PIPE_CTRL_STALL_WDT_EN and WDT_LIMIT=8:
  - stallreq_ex_i held 8 cycles → wdt_timeout_o=1 and stays 1 after the stall is released.
  - Holding stallreq_ex_i only 7 cycles then releasing → wdt_timeout_o stays 0.
